// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: decodes a byte address into data memory, output
// registers and input ports, with sub-word merge/extract and programmable wait states.
module lsu_mc #(
    parameter int DMEM_DEPTH  = 2048,
    parameter int WAIT_CYCLES = 1,
    parameter int NUM_OUT     = 4,
    parameter int NUM_IN      = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req,
    input  logic                    i_wren,
    input  logic [31:0]             i_addr,
    input  logic [1:0]              i_size,
    input  logic                    i_unsigned,
    input  logic [31:0]             i_st_data,
    input  logic [32*NUM_IN-1:0]    i_in_data,
    output logic                    o_busy,
    output logic                    o_ack,
    output logic [31:0]             o_ld_data,
    output logic                    o_misalign,
    output logic [32*NUM_OUT-1:0]   o_out_data
);

    localparam int AW = $clog2(DMEM_DEPTH);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [31:0] OUT_BASE = 32'h1000_0000;
    localparam logic [31:0] IN_BASE  = 32'h1001_0000;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t         state_q, state_d;
    logic [31:0]    addr_q;
    logic [1:0]     size_q;
    logic           wren_q;
    logic           uns_q;
    logic [31:0]    st_q;
    logic [CW-1:0]  cnt_q;
    logic [31:0]    ld_q;
    logic           mis_q;
    logic [31:0]    out_q [NUM_OUT];

    logic [31:0]    mem [DMEM_DEPTH];
    logic [31:0]    rd_q;
    logic [AW-1:0]  rd_idx;

    logic           accept;
    logic           mis_in;
    logic           hit_dmem;
    logic [NUM_OUT-1:0] out_hit;
    logic [31:0]    rd_word;
    logic [31:0]    wr_word;
    logic [31:0]    ld_word;
    logic [31:0]    shifted;
    logic           mem_we;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        return (sz == 2'd3) || (sz == 2'd1 && lo[0]) || (sz == 2'd2 && lo != 2'd0);
    endfunction

    assign accept = (state_q == S_IDLE) && i_req;
    assign mis_in = is_misaligned(i_size, i_addr[1:0]);

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    if (mis_in)               state_d = S_RESP;
                    else if (WAIT_CYCLES > 0) state_d = S_WAIT;
                    else                      state_d = S_ACCESS;
                end
            end
            S_WAIT:   if (cnt_q == '0) state_d = S_ACCESS;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Address decode and read mux, all from the latched request.
    always_comb begin
        hit_dmem = ((addr_q >> (AW + 2)) == 32'd0);
        rd_word  = '0;
        out_hit  = '0;
        if (hit_dmem) rd_word = rd_q;
        for (int k = 0; k < NUM_OUT; k++) begin
            if ({addr_q[31:2], 2'b00} == OUT_BASE + 32'(16 * k)) begin
                out_hit[k] = 1'b1;
                rd_word    = out_q[k];
            end
        end
        for (int k = 0; k < NUM_IN; k++) begin
            if ({addr_q[31:2], 2'b00} == IN_BASE + 32'(16 * k)) begin
                rd_word = i_in_data[32*k +: 32];
            end
        end
    end

    always_comb begin
        wr_word = rd_word;
        case (size_q)
            2'd0:    wr_word[{addr_q[1:0], 3'b000} +: 8]  = st_q[7:0];
            2'd1:    wr_word[{addr_q[1], 4'b0000} +: 16] = st_q[15:0];
            default: wr_word = st_q;
        endcase
    end

    always_comb begin
        shifted = rd_word >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'd0:    ld_word = uns_q ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    ld_word = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_word = rd_word;
        endcase
    end

    // Read index follows the incoming address in IDLE so a zero-wait access still
    // finds its word registered on entry to ACCESS.
    assign rd_idx = (state_q == S_IDLE) ? i_addr[AW+1:2] : addr_q[AW+1:2];
    assign mem_we = (state_q == S_ACCESS) && wren_q && hit_dmem && !i_rst;

    always_ff @(posedge i_clk) begin
        rd_q <= mem[rd_idx];
        if (mem_we) mem[addr_q[AW+1:2]] <= wr_word;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q <= '0;
            size_q <= '0;
            wren_q <= 1'b0;
            uns_q  <= 1'b0;
            st_q   <= '0;
            cnt_q  <= '0;
            ld_q   <= '0;
            mis_q  <= 1'b0;
            for (int k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
        end else begin
            if (accept) begin
                addr_q <= i_addr;
                size_q <= i_size;
                wren_q <= i_wren;
                uns_q  <= i_unsigned;
                st_q   <= i_st_data;
                if (WAIT_CYCLES > 0) cnt_q <= CW'(WAIT_CYCLES - 1);
                if (mis_in) begin
                    ld_q  <= '0;
                    mis_q <= 1'b1;
                end
            end
            if (state_q == S_WAIT && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            if (state_q == S_ACCESS) begin
                mis_q <= 1'b0;
                if (!wren_q) ld_q <= ld_word;
                for (int k = 0; k < NUM_OUT; k++) begin
                    if (wren_q && out_hit[k]) out_q[k] <= wr_word;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_OUT; g++) begin : g_out
            assign o_out_data[32*g +: 32] = out_q[g];
        end
    endgenerate

    assign o_busy     = (state_q != S_IDLE);
    assign o_ack      = (state_q == S_RESP);
    assign o_ld_data  = ld_q;
    assign o_misalign = mis_q;

endmodule

// File: tb/tb_lsu_mc.sv
// Directed bench for lsu_mc: a one-wait-state unit driven op by op, and a
// zero-wait unit driven with a continuously held request.
module tb_lsu_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         req = 1'b0, wren = 1'b0, uns = 1'b0;
    logic [31:0]  addr = '0, st_data = '0, in_data = '0;
    logic [1:0]   size = '0;
    logic         busy, ack, mis;
    logic [31:0]  ld;
    logic [127:0] out_data;

    logic         r0_req = 1'b0, r0_wren = 1'b0, r0_uns = 1'b0;
    logic [31:0]  r0_addr = '0, r0_st = '0, r0_in = '0;
    logic [1:0]   r0_size = '0;
    logic         r0_busy, r0_ack, r0_mis;
    logic [31:0]  r0_ld;
    logic [127:0] r0_out;

    lsu_mc #(.DMEM_DEPTH(2048), .WAIT_CYCLES(1), .NUM_OUT(4), .NUM_IN(1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_wren(wren), .i_addr(addr),
        .i_size(size), .i_unsigned(uns), .i_st_data(st_data), .i_in_data(in_data),
        .o_busy(busy), .o_ack(ack), .o_ld_data(ld), .o_misalign(mis), .o_out_data(out_data)
    );

    lsu_mc #(.DMEM_DEPTH(2048), .WAIT_CYCLES(0), .NUM_OUT(4), .NUM_IN(1)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_req(r0_req), .i_wren(r0_wren), .i_addr(r0_addr),
        .i_size(r0_size), .i_unsigned(r0_uns), .i_st_data(r0_st), .i_in_data(r0_in),
        .o_busy(r0_busy), .o_ack(r0_ack), .o_ld_data(r0_ld), .o_misalign(r0_mis), .o_out_data(r0_out)
    );

    int checks = 0;
    int failures = 0;
    // {check load data, expected misalign, expected load data}
    logic [33:0] exp_q[$];
    logic [31:0] m [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        req     = 1'($urandom_range(0, 1));
        wren    = 1'($urandom_range(0, 1));
        uns     = 1'($urandom_range(0, 1));
        size    = 2'($urandom_range(0, 3));
        addr    = $urandom;
        st_data = $urandom;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_ack"},  {31'd0, ack},  32'd0);
        check({tag, "_ld"},   ld, 32'd0);
        check({tag, "_mis"},  {31'd0, mis},  32'd0);
        for (int k = 0; k < 4; k++) check({tag, "_out"}, out_data[32*k +: 32], 32'd0);
    endtask

    // Called at a negedge with the unit idle; returns at the negedge after it is idle again.
    task automatic do_op(input string tag, input logic wr, input logic [31:0] a,
                         input logic [1:0] sz, input logic u, input logic [31:0] sd,
                         input logic [31:0] exp_ld, input logic exp_mis, input int exp_lat);
        logic [33:0] e;
        int k;
        req = 1'b1; wren = wr; addr = a; size = sz; uns = u; st_data = sd;
        exp_q.push_back({(!wr) | exp_mis, exp_mis, exp_ld});
        @(negedge clk);
        k = 1;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        scramble();
        while (!ack && k < 20) begin
            @(negedge clk);
            k++;
            scramble();
        end
        check({tag, "_lat"}, k, exp_lat);
        e = exp_q.pop_front();
        if (ack) begin
            if (e[33]) check({tag, "_ld"}, ld, e[31:0]);
            check({tag, "_mis"}, {31'd0, mis}, {31'd0, e[32]});
        end
        @(negedge clk);
        req = 1'b0;
        check({tag, "_ackoff"}, {31'd0, ack}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic no_ack_window(input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) seen++;
        end
        check({tag, "_noack"}, seen, 32'd0);
    endtask

    initial begin
        logic [1:0]  lane;
        logic [7:0]  b;
        logic [33:0] e;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset("reset");

        do_op("w_st",  1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 3);
        do_op("w_ld",  1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 3);

        do_op("m_st",  1'b1, 32'h20, 2'd2, 1'b0, 32'h11223344, 32'h0, 1'b0, 3);
        do_op("b_st",  1'b1, 32'h22, 2'd0, 1'b0, 32'hFFFF00A5, 32'h0, 1'b0, 3);
        do_op("m_ldw", 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 32'h11A53344, 1'b0, 3);
        do_op("b_lds", 1'b0, 32'h22, 2'd0, 1'b0, 32'h0, 32'hFFFFFFA5, 1'b0, 3);
        do_op("b_ldu", 1'b0, 32'h22, 2'd0, 1'b1, 32'h0, 32'h000000A5, 1'b0, 3);
        do_op("h_lds", 1'b0, 32'h22, 2'd1, 1'b0, 32'h0, 32'h000011A5, 1'b0, 3);
        do_op("b_ld0", 1'b0, 32'h20, 2'd0, 1'b0, 32'h0, 32'h00000044, 1'b0, 3);

        do_op("mis_hst", 1'b1, 32'h23, 2'd1, 1'b0, 32'h0000BBBB, 32'h0, 1'b1, 1);
        do_op("mis_wld", 1'b0, 32'h21, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 1);
        do_op("mis_sz3", 1'b1, 32'h20, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, 1);
        do_op("mis_keep", 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 32'h11A53344, 1'b0, 3);

        do_op("io_st1", 1'b1, 32'h1000_0010, 2'd2, 1'b0, 32'h000000FF, 32'h0, 1'b0, 3);
        check("io_out1", out_data[63:32], 32'h000000FF);
        do_op("io_stb0", 1'b1, 32'h1000_0001, 2'd0, 1'b0, 32'h00000077, 32'h0, 1'b0, 3);
        check("io_out0", out_data[31:0], 32'h00007700);
        in_data = 32'h00001234;
        do_op("io_in",  1'b0, 32'h1001_0000, 2'd2, 1'b0, 32'h0, 32'h00001234, 1'b0, 3);
        do_op("io_stin", 1'b1, 32'h1001_0000, 2'd2, 1'b0, 32'h55555555, 32'h0, 1'b0, 3);
        do_op("io_stun", 1'b1, 32'h2000_0000, 2'd2, 1'b0, 32'h66666666, 32'h0, 1'b0, 3);
        check("io_keep0", out_data[31:0],   32'h00007700);
        check("io_keep1", out_data[63:32],  32'h000000FF);
        check("io_keep2", out_data[95:64],  32'h0);
        check("io_keep3", out_data[127:96], 32'h0);
        do_op("io_ldun", 1'b0, 32'h2000_0000, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 3);
        do_op("io_rdbk", 1'b0, 32'h1000_0010, 2'd2, 1'b0, 32'h0, 32'h000000FF, 1'b0, 3);
        do_op("io_inb",  1'b0, 32'h1001_0001, 2'd0, 1'b1, 32'h0, 32'h00000012, 1'b0, 3);

        do_op("r_pre",  1'b1, 32'h40, 2'd2, 1'b0, 32'h12345678, 32'h0, 1'b0, 3);
        do_op("r_pld",  1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 32'h12345678, 1'b0, 3);
        req = 1'b1; wren = 1'b1; addr = 32'h40; size = 2'd2; st_data = 32'hCAFEF00D;
        @(negedge clk);
        req = 1'b0;
        check("rw_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("rw");
        no_ack_window("rw");
        do_op("rw_keep", 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 32'h12345678, 1'b0, 3);

        do_op("rc_st1", 1'b1, 32'h1000_0020, 2'd2, 1'b0, 32'h0000ABCD, 32'h0, 1'b0, 3);
        req = 1'b1; wren = 1'b1; addr = 32'h40; size = 2'd2; st_data = 32'hCAFEF00D;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("rc_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("rc");
        no_ack_window("rc");
        do_op("rc_keep", 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 32'h12345678, 1'b0, 3);

        // Zero-wait unit with the request held high throughout.
        for (int j = 0; j < 9; j++) begin
            r0_req = 1'b1; r0_uns = 1'b0; r0_st = 32'h0;
            if (j < 4) begin
                m[j] = $urandom;
                r0_wren = 1'b1; r0_addr = 32'(4 * j); r0_size = 2'd2; r0_st = m[j];
            end else if (j == 4) begin
                lane = 2'($urandom_range(0, 3));
                b = 8'($urandom);
                m[1][8*lane +: 8] = b;
                r0_wren = 1'b1; r0_addr = 32'h4 + {30'd0, lane}; r0_size = 2'd0;
                r0_st = {24'hFFFFFF, b};
            end else begin
                r0_wren = 1'b0; r0_addr = 32'(4 * (j - 5)); r0_size = 2'd2;
            end
            exp_q.push_back({!r0_wren, 1'b0, r0_wren ? 32'h0 : m[j-5 >= 0 ? j-5 : 0]});
            @(negedge clk);
            check("h_busy", {31'd0, r0_busy}, 32'd1);
            check("h_ack0", {31'd0, r0_ack}, 32'd0);
            r0_wren = 1'($urandom_range(0, 1)); r0_addr = $urandom & 32'hC;
            r0_size = 2'($urandom_range(0, 3)); r0_st = $urandom; r0_uns = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("h_ack1", {31'd0, r0_ack}, 32'd1);
            e = exp_q.pop_front();
            if (e[33]) check("h_ld", r0_ld, e[31:0]);
            check("h_mis", {31'd0, r0_mis}, 32'd0);
            r0_wren = 1'($urandom_range(0, 1)); r0_addr = $urandom;
            r0_st = $urandom;
            @(negedge clk);
            check("h_ack2", {31'd0, r0_ack}, 32'd0);
            check("h_idle", {31'd0, r0_busy}, 32'd0);
        end
        r0_req = 1'b0;

        check("sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
